// File: rtl/conv_mac_chain.sv
// Weight-stationary transposed-form D-tap MAC chain with bias, valid/ready handshake and serial
// weight loading. Define CONV_MAC_CHAIN_SAT_EN to clamp every add instead of wrapping.
module conv_mac_chain #(
   parameter int unsigned XW = 8,
   parameter int unsigned WW = 8,
   parameter int unsigned BW = 20,
   parameter int unsigned D  = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [XW-1:0] i_x,
   input  logic [BW-1:0] i_bias,
   input  logic          i_w_load,
   input  logic [WW-1:0] i_w,
   input  logic          i_clear,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [BW-1:0] o_psum,
   output logic          o_w_loaded
);

   localparam int unsigned PW = XW + WW;
   localparam int unsigned CW = $clog2(D + 1);

`ifdef CONV_MAC_CHAIN_SAT_EN
   localparam logic signed [BW-1:0] SatMax = $signed({1'b0, {(BW-1){1'b1}}});
   localparam logic signed [BW-1:0] SatMin = $signed({1'b1, {(BW-1){1'b0}}});

   function automatic logic signed [BW-1:0] add2(input logic signed [BW-1:0] a,
                                                 input logic signed [BW-1:0] b);
      logic signed [BW:0] sum;
      sum = (BW+1)'(a) + (BW+1)'(b);
      if (sum > (BW+1)'(SatMax)) return SatMax;
      if (sum < (BW+1)'(SatMin)) return SatMin;
      return sum[BW-1:0];
   endfunction

   // The output add is clamped once on the exact three-operand sum.
   function automatic logic signed [BW-1:0] add3(input logic signed [BW-1:0] a,
                                                 input logic signed [BW-1:0] b,
                                                 input logic signed [BW-1:0] c);
      logic signed [BW+1:0] sum;
      sum = (BW+2)'(a) + (BW+2)'(b) + (BW+2)'(c);
      if (sum > (BW+2)'(SatMax)) return SatMax;
      if (sum < (BW+2)'(SatMin)) return SatMin;
      return sum[BW-1:0];
   endfunction
`else
   function automatic logic signed [BW-1:0] add2(input logic signed [BW-1:0] a,
                                                 input logic signed [BW-1:0] b);
      return a + b;
   endfunction

   function automatic logic signed [BW-1:0] add3(input logic signed [BW-1:0] a,
                                                 input logic signed [BW-1:0] b,
                                                 input logic signed [BW-1:0] c);
      return a + b + c;
   endfunction
`endif

   logic signed [WW-1:0] w_q [D];
   logic [CW-1:0]        cnt_q;
   // s_q[k-1] holds stage register s[k], k = 1..D-1.
   logic signed [BW-1:0] s_q [D-1];
   logic signed [BW-1:0] s_d [D-1];
   logic signed [PW-1:0] prod_full [D];
   logic signed [BW-1:0] prod [D];
   logic signed [BW-1:0] psum_q, psum_d;
   logic                 valid_q;
   logic                 acc;

   assign o_ready    = !valid_q || i_ready;
   assign acc        = i_valid && o_ready;
   assign o_valid    = valid_q;
   assign o_psum     = psum_q;
   assign o_w_loaded = (cnt_q == CW'(D));

   always_comb begin
      for (int k = 0; k < D; k++) begin
         prod_full[k] = w_q[k] * $signed(i_x);
         prod[k]      = BW'(prod_full[k]);
      end
      s_d[D-2] = prod[D-1];
      for (int k = 1; k < D - 1; k++) begin
         s_d[k-1] = add2(s_q[k], prod[k]);
      end
      psum_d = add3($signed(i_bias), s_q[0], prod[0]);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < D; k++) w_q[k] <= '0;
         for (int k = 0; k < D - 1; k++) s_q[k] <= '0;
         cnt_q   <= '0;
         psum_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (i_w_load) begin
            for (int k = 0; k < D - 1; k++) w_q[k] <= w_q[k+1];
            w_q[D-1] <= $signed(i_w);
            if (cnt_q != CW'(D)) cnt_q <= cnt_q + 1'b1;
         end
         // Clear wins over a same-cycle accept; that sample is dropped.
         if (i_clear) begin
            for (int k = 0; k < D - 1; k++) s_q[k] <= '0;
            valid_q <= 1'b0;
         end else if (acc) begin
            s_q     <= s_d;
            psum_q  <= psum_d;
            valid_q <= 1'b1;
         end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule
